reg_snapshot_reader: RTL and testbench

Read-side companion to the processor's 4-bit enable/reset register bank. On a single `start` strobe it captures a coherent snapshot of every register's value. It then streams the captured words out one at a time over a valid/ready handshake, in index order, for debug readout or trace logic. Snapshot capture isolates the stream from register writes that occur during readout.

---
 rtl/reg_snapshot_reader_if.sv | 14 +
 rtl/reg_snapshot_reader.sv | 99 +++++++++
 tb/tb_reg_snapshot_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/reg_snapshot_reader_if.sv
// Word stream from the snapshot reader: valid/ready handshake carrying one
// register value and its index per transfer.
interface reg_snapshot_reader_if #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 2
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [IDX_W-1:0] out_index;

   modport master (output out_valid, output out_data, output out_index, input out_ready);
   modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/reg_snapshot_reader.sv
// Captures a coherent snapshot of the enable/reset register bank on start and
// streams the captured words out in index order over a valid/ready handshake.
module reg_snapshot_reader #(
   parameter int NUM_REGS = 4,
   parameter int WIDTH    = 4,
   parameter int IDX_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [NUM_REGS*WIDTH-1:0] reg_bus,
   reg_snapshot_reader_if.master     out,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] snap [NUM_REGS];
   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic [IDX_W-1:0] index_q;
   logic             done_q;
   logic             capture, advance, finish;
   logic [IDX_W-1:0] index_next;

   assign index_next = index_q + IDX_W'(1);

   // NOTE: every combinational output gets a default before the case so that no
   // path leaves it unassigned; an unassigned path would infer a latch.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (valid_q && out.out_ready) begin
               if (index_q == LAST_IDX) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here so every register samples pre-edge
   // values; blocking ones would make the result depend on statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         index_q <= '0;
         done_q  <= 1'b0;
         // NOTE: storage arrays are normally left unreset; this one is tiny and
         // must read back as zero after reset, so it is cleared explicitly.
         for (int i = 0; i < NUM_REGS; i++) snap[i] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= finish;
         if (capture) begin
            for (int i = 0; i < NUM_REGS; i++) snap[i] <= reg_bus[i*WIDTH +: WIDTH];
            // First word comes straight from the bus since the snapshot is still loading.
            data_q  <= reg_bus[WIDTH-1:0];
            index_q <= '0;
            valid_q <= 1'b1;
         end else if (advance) begin
            data_q  <= snap[index_next];
            index_q <= index_next;
         end else if (finish) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign out.out_valid = valid_q;
   assign out.out_data  = data_q;
   assign out.out_index = index_q;
   assign busy          = (state_q == SEND);
   assign done          = done_q;

endmodule

// File: tb/tb_reg_snapshot_reader.sv
// Directed bench for reg_snapshot_reader: readout, back-pressure, isolation,
// start-while-busy, mid-stream reset and back-to-back streams.
module tb_reg_snapshot_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] reg_bus;
   logic        busy;
   logic        done;
   int          n_assert = 0;
   int          n_fail   = 0;

   reg_snapshot_reader_if #(.WIDTH(4), .IDX_W(2)) sif ();

   reg_snapshot_reader #(.NUM_REGS(4), .WIDTH(4), .IDX_W(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .reg_bus (reg_bus),
      .out     (sif.master),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic expect_word(input string tag, input logic [1:0] idx, input logic [3:0] data);
      check({tag, " valid"}, 32'(sif.out_valid), 32'd1);
      check({tag, " index"}, 32'(sif.out_index), 32'(idx));
      check({tag, " data"},  32'(sif.out_data),  32'(data));
      check({tag, " busy"},  32'(busy),          32'd1);
      check({tag, " done"},  32'(done),          32'd0);
   endtask

   task automatic expect_done(input string tag);
      check({tag, " done"},  32'(done),          32'd1);
      check({tag, " valid"}, 32'(sif.out_valid), 32'd0);
      check({tag, " busy"},  32'(busy),          32'd0);
   endtask

   task automatic expect_idle(input string tag);
      check({tag, " done"},  32'(done),          32'd0);
      check({tag, " valid"}, 32'(sif.out_valid), 32'd0);
      check({tag, " busy"},  32'(busy),          32'd0);
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      reg_bus       = 16'h0000;
      sif.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst valid", 32'(sif.out_valid), 32'd0);
      check("rst busy",  32'(busy),          32'd0);
      check("rst done",  32'(done),          32'd0);
      check("rst index", 32'(sif.out_index), 32'd0);
      check("rst data",  32'(sif.out_data),  32'd0);

      // Basic readout
      reg_bus       = 16'hA5C3;
      sif.out_ready = 1'b1;
      launch();
      expect_word("t1 w0", 2'd0, 4'h3);
      tick(); expect_word("t1 w1", 2'd1, 4'hC);
      tick(); expect_word("t1 w2", 2'd2, 4'h5);
      tick(); expect_word("t1 w3", 2'd3, 4'hA);
      tick(); expect_done("t1 end");
      tick(); expect_idle("t1 after");

      // Back-pressure on word 1
      launch();
      expect_word("t2 w0", 2'd0, 4'h3);
      tick(); expect_word("t2 w1", 2'd1, 4'hC);
      sif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); expect_word("t2 stall", 2'd1, 4'hC);
      end
      sif.out_ready = 1'b1;
      tick(); expect_word("t2 w2", 2'd2, 4'h5);
      tick(); expect_word("t2 w3", 2'd3, 4'hA);
      tick(); expect_done("t2 end");
      tick(); expect_idle("t2 after");

      // Snapshot isolation: bus rewritten after the capture edge
      launch();
      reg_bus = 16'hFFFF;
      expect_word("t3 w0", 2'd0, 4'h3);
      tick(); reg_bus = 16'hFFFF; expect_word("t3 w1", 2'd1, 4'hC);
      tick(); reg_bus = 16'hFFFF; expect_word("t3 w2", 2'd2, 4'h5);
      tick(); reg_bus = 16'hFFFF; expect_word("t3 w3", 2'd3, 4'hA);
      tick(); expect_done("t3 end");
      reg_bus = 16'hA5C3;
      tick(); expect_idle("t3 after");

      // Start while busy is ignored and not queued
      launch();
      expect_word("t4 w0", 2'd0, 4'h3);
      tick(); expect_word("t4 w1", 2'd1, 4'hC);
      tick(); expect_word("t4 w2", 2'd2, 4'h5);
      start = 1'b1;
      tick(); start = 1'b0; expect_word("t4 w3", 2'd3, 4'hA);
      tick(); expect_done("t4 end");
      tick(); expect_idle("t4 after1");
      tick(); expect_idle("t4 after2");

      // Reset mid-stream at index 2
      launch();
      expect_word("t5 w0", 2'd0, 4'h3);
      tick(); expect_word("t5 w1", 2'd1, 4'hC);
      tick(); expect_word("t5 w2", 2'd2, 4'h5);
      reset = 1'b1;
      tick(); reset = 1'b0;
      expect_idle("t5 rst");
      check("t5 rst index", 32'(sif.out_index), 32'd0);
      check("t5 rst data",  32'(sif.out_data),  32'd0);
      tick(); expect_idle("t5 post");

      // Reset and start together: reset wins
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      expect_idle("t5 rst+start");
      tick(); expect_idle("t5 rst+start2");

      reg_bus = 16'h1234;
      launch();
      expect_word("t5 w0'", 2'd0, 4'h4);
      tick(); expect_word("t5 w1'", 2'd1, 4'h3);
      tick(); expect_word("t5 w2'", 2'd2, 4'h2);
      tick(); expect_word("t5 w3'", 2'd3, 4'h1);
      tick(); expect_done("t5 end");

      // Back-to-back: start sampled in the done cycle
      reg_bus = 16'h0F0F;
      launch();
      expect_word("t6 w0", 2'd0, 4'hF);
      tick(); expect_word("t6 w1", 2'd1, 4'h0);
      tick(); expect_word("t6 w2", 2'd2, 4'hF);
      tick(); expect_word("t6 w3", 2'd3, 4'h0);
      tick(); expect_done("t6 end");
      tick(); expect_idle("t6 after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
